jk_reg_bank: RTL and testbench



---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_next_cell.sv | 43 ++++
 rtl/jk_reg_bank.sv | 94 +++++++++
 tb/tb_jk_reg_bank.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the jk_reg_bank register primitive: function-select
// encodings as an enum for RTL and as plain 2-bit constants for benches.
package jk_pkg;

  typedef enum logic [1:0] {
    FF_JK = 2'd0,
    FF_D  = 2'd1,
    FF_T  = 2'd2,
    FF_SR = 2'd3
  } ff_mode_e;

  localparam logic [1:0] MODE_JK = 2'd0;
  localparam logic [1:0] MODE_D  = 2'd1;
  localparam logic [1:0] MODE_T  = 2'd2;
  localparam logic [1:0] MODE_SR = 2'd3;

endpackage

// File: rtl/jk_next_cell.sv
// Combinational next-state function for one storage bit in JK/D/T/SR mode,
// plus a flag marking the illegal SR 11 input.
module jk_next_cell
  import jk_pkg::*;
(
  input  ff_mode_e mode,
  input  logic     j,
  input  logic     k,
  input  logic     q,
  output logic     q_next,
  output logic     illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    unique case (mode)
      FF_JK: begin
        unique case ({j, k})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: q_next = ~q;
        endcase
      end
      FF_D: q_next = j;
      FF_T: q_next = q ^ j;
      FF_SR: begin
        unique case ({j, k})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: begin
            // Both set and reset requested: keep the bit and report it.
            q_next  = q;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK-style bits with selectable JK/D/T/SR function, clear, load,
// enable, change indicator. Sticky SR-illegal flag built when JK_REG_BANK_ERR_EN is defined.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] changed,
  output logic             err
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] changed_reg;
  logic [WIDTH-1:0] func_next;
  logic [WIDTH-1:0] illegal;
  ff_mode_e         mode_sel;

  assign mode_sel = ff_mode_e'(mode);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_next_cell u_cell (
        .mode    (mode_sel),
        .j       (j[gi]),
        .k       (k[gi]),
        .q       (q_reg[gi]),
        .q_next  (func_next[gi]),
        .illegal (illegal[gi])
      );
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    if (clear) begin
      q_next = '0;
    end else if (load) begin
      q_next = load_data;
    end else if (en) begin
      q_next = func_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg       <= RESET_VAL;
      changed_reg <= '0;
    end else begin
      q_reg       <= q_next;
      changed_reg <= q_next ^ q_reg;
    end
  end

  assign q       = q_reg;
  assign changed = changed_reg;

`ifdef JK_REG_BANK_ERR_EN
  logic err_reg;
  logic err_set;

  // Only an SR function that actually executes can raise the flag.
  assign err_set = (mode_sel == FF_SR) && en && !clear && !load && (|illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end else if (err_clr) begin
      err_reg <= 1'b0;
    end
  end

  assign err = err_reg;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, illegal};
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_reg_bank;
  import jk_pkg::*;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
`ifdef JK_REG_BANK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         clear;
  logic         load;
  logic [W-1:0] load_data;
  logic         err_clr;
  logic [W-1:0] q;
  logic [W-1:0] changed;
  logic         err;

  int errors = 0;
  int checks = 0;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .j         (j),
    .k         (k),
    .clear     (clear),
    .load      (load),
    .load_data (load_data),
    .err_clr   (err_clr),
    .q         (q),
    .changed   (changed),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] jv,
                       input logic [7:0] kv, input logic c, input logic l,
                       input logic [7:0] ld, input logic ec);
    en = e; mode = m; j = jv; k = kv; clear = c; load = l; load_data = ld; err_clr = ec;
  endtask

  task automatic step(input string tag, input logic [7:0] exp_q,
                      input logic [7:0] exp_ch, input logic exp_err);
    @(posedge clk);
    #1;
    $display("step %-10s mode=%0d j=%h k=%h en=%b clr=%b ld=%b -> q=%h changed=%h err=%b",
             tag, mode, j, k, en, clear, load, q, changed, err);
    chk({tag, ".q"}, q, exp_q);
    chk({tag, ".changed"}, changed, exp_ch);
    chk({tag, ".err"}, {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, MODE_JK, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    chk("rst.q", q, RV);
    chk("rst.changed", changed, 8'h00);
    chk("rst.err", {7'd0, err}, 8'h00);
    reset = 1'b0;

    step("hold", 8'hA5, 8'h00, 1'b0);
    drive(1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step("clear", 8'h00, 8'hA5, 1'b0);

    drive(1'b1, MODE_JK, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0);
    step("jk_sr", 8'hF0, 8'hF0, 1'b0);
    drive(1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    step("jk_tog", 8'h0F, 8'hFF, 1'b0);

    drive(1'b1, MODE_T, 8'h03, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    step("t", 8'h0C, 8'h03, 1'b0);
    drive(1'b0, MODE_T, 8'h03, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    step("en0", 8'h0C, 8'h00, 1'b0);

    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
    step("load", 8'h3C, 8'h30, 1'b0);
    step("load_same", 8'h3C, 8'h00, 1'b0);
    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0);
    step("clr_ld", 8'h00, 8'h3C, 1'b0);

    // SR: bit7 set, bit0 illegal and holds
    drive(1'b1, MODE_SR, 8'h81, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    step("sr_ill", 8'h80, 8'h80, ERR_ON);
    drive(1'b1, MODE_SR, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    step("errclr", 8'h81, 8'h01, 1'b0);
    drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    step("sr_ill2", 8'h81, 8'h00, ERR_ON);
    drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    step("set_wins", 8'h81, 8'h00, ERR_ON);
    // clear suppresses detection but does not clear err
    drive(1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    step("clr_err", 8'h00, 8'h81, ERR_ON);
    drive(1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h81, 1'b0);
    step("ld_noerr", 8'h81, 8'h81, ERR_ON);
    drive(1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1);
    step("errclr2", 8'h81, 8'h00, 1'b0);

    drive(1'b1, MODE_D, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step("d", 8'h5A, 8'hDB, 1'b0);
    drive(1'b1, MODE_JK, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step("jk_hold", 8'h5A, 8'h00, 1'b0);
    drive(1'b1, MODE_SR, 8'h00, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0);
    step("sr_rst", 8'h50, 8'h0A, 1'b0);

    // asynchronous reset in mid-cycle, with a load pending across an edge
    drive(1'b0, MODE_JK, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst.q", q, RV);
    chk("arst.changed", changed, 8'h00);
    chk("arst.err", {7'd0, err}, 8'h00);
    step("rst_hold", RV, 8'h00, 1'b0);
    reset = 1'b0;
    step("post_rst", 8'hFF, 8'h5A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
